// File: rtl/button_pkg.sv
// Shared button indices, repeat FSM states and counter sizing for the
// time-setting pushbutton front-end.
package button_pkg;

   localparam int BTN_START = 0;
   localparam int BTN_UP    = 1;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_LEFT  = 3;
   localparam int BTN_RIGHT = 4;
   localparam int NUM_BTN   = 5;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rpt_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton: two-flop synchroniser, debounce counter, debounced level
// and registered press pulse, plus the flip events for the repeat logic.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic held_o,
   output logic press_o,
   output logic press_evt_o,
   output logic release_evt_o
);

   localparam int            CW   = cnt_w(DEBOUNCE_CYC);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync_q;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q;
   logic          differ;
   logic          flip;

   always_comb begin
      differ = (~sync_q[1]) != db_q;
      flip   = differ && (cnt_q == TERM);
      db_d   = flip ? ~db_q : db_q;
      cnt_d  = (differ && !flip) ? cnt_q + CW'(1) : '0;
   end

   // Synchroniser resets to "released" so a key held through reset re-debounces.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 2'b11;
         db_q    <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_ni};
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= flip & ~db_q;
      end
   end

   assign held_o        = db_q;
   assign press_o       = press_q;
   assign press_evt_o   = flip & ~db_q;
   assign release_evt_o = flip & db_q;

endmodule

// File: rtl/button_conditioner.sv
// Five-button front-end: debounced press pulses, held levels, and
// hold-to-repeat on up/down with a freeze while both are held together.
module button_conditioner
   import button_pkg::*;
#(
   parameter int                 DEBOUNCE_CYC      = 500000,
   parameter int                 REPEAT_DELAY_CYC  = 25000000,
   parameter int                 REPEAT_PERIOD_CYC = 5000000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK       = 5'b00110
) (
   input  logic               clk_50MHz,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] key_n,
   output logic               start,
   output logic               up,
   output logic               down,
   output logic               left,
   output logic               right,
   output logic [NUM_BTN-1:0] held
);

   localparam int TW = cnt_w((REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                             REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC);
   localparam logic [TW-1:0] DELAY_TERM  = TW'(REPEAT_DELAY_CYC - 1);
   localparam logic [TW-1:0] PERIOD_TERM = TW'(REPEAT_PERIOD_CYC - 1);

   logic [NUM_BTN-1:0] db_held;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] press_evt;
   logic [NUM_BTN-1:0] rel_evt;
   logic [NUM_BTN-1:0] rpt;
   logic               conflict;

   assign conflict = db_held[BTN_UP] & db_held[BTN_DOWN];

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      logic       freeze;
      rpt_state_e state_q, state_d;
      logic [TW-1:0] tmr_q, tmr_d;
      logic       rpt_q, rpt_d;

      button_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
         .clk_i         (clk_50MHz),
         .rst_ni        (reset),
         .key_ni        (key_n[b]),
         .held_o        (db_held[b]),
         .press_o       (press[b]),
         .press_evt_o   (press_evt[b]),
         .release_evt_o (rel_evt[b])
      );

      assign freeze = conflict && ((b == BTN_UP) || (b == BTN_DOWN));

      // Buttons without repeat never leave IDLE, so their FSM folds away.
      always_comb begin
         state_d = state_q;
         tmr_d   = tmr_q;
         rpt_d   = 1'b0;
         if (rel_evt[b]) begin
            state_d = IDLE;
            tmr_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (press_evt[b] && REPEAT_MASK[b]) begin
                     state_d = DELAY;
                     tmr_d   = '0;
                  end
               end
               DELAY: begin
                  if (!freeze) begin
                     if (tmr_q == DELAY_TERM) begin
                        rpt_d   = 1'b1;
                        state_d = REPEAT;
                        tmr_d   = '0;
                     end else begin
                        tmr_d = tmr_q + TW'(1);
                     end
                  end
               end
               REPEAT: begin
                  if (!freeze) begin
                     if (tmr_q == PERIOD_TERM) begin
                        rpt_d = 1'b1;
                        tmr_d = '0;
                     end else begin
                        tmr_d = tmr_q + TW'(1);
                     end
                  end
               end
               default: begin
                  state_d = IDLE;
                  tmr_d   = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk_50MHz or negedge reset) begin
         if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rpt_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rpt_q   <= rpt_d;
         end
      end

      assign rpt[b] = rpt_q;
   end

   assign start = press[BTN_START] | rpt[BTN_START];
   assign up    = press[BTN_UP]    | rpt[BTN_UP];
   assign down  = press[BTN_DOWN]  | rpt[BTN_DOWN];
   assign left  = press[BTN_LEFT]  | rpt[BTN_LEFT];
   assign right = press[BTN_RIGHT] | rpt[BTN_RIGHT];
   assign held  = db_held;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/repeat intervals; a
// behavioural model tracks debounce runs and hold ages per button.
module tb_button_conditioner;
   import button_pkg::*;

   localparam int            DB   = 4;
   localparam int            RD   = 20;
   localparam int            RP   = 8;
   localparam logic [4:0]    MASK = 5'b00110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] key_n = 5'b11111;
   logic       start, up, down, left, right;
   logic [4:0] held;

   button_conditioner #(
      .DEBOUNCE_CYC      (DB),
      .REPEAT_DELAY_CYC  (RD),
      .REPEAT_PERIOD_CYC (RP),
      .REPEAT_MASK       (MASK)
   ) dut (
      .clk_50MHz (clk),
      .reset     (rst_n),
      .key_n     (key_n),
      .start     (start),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .held      (held)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int edge_n  = 0;

   // Model: raw samples two edges old, debounced level, disagreement run
   // length, and for repeat buttons the count of unfrozen cycles since press.
   logic [4:0] m_s1, m_s2, m_db, m_pulse, m_rpt, m_act;
   int         m_cnt [5];
   int         m_run [5];

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_db = '0; m_pulse = '0; m_rpt = '0; m_act = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
         m_cnt[b] = 0;
         m_run[b] = 0;
      end
   endtask

   task automatic model_step();
      logic conflict, differ, press, rel;
      conflict = m_db[BTN_UP] & m_db[BTN_DOWN];
      for (int b = 0; b < NUM_BTN; b++) begin
         m_pulse[b] = 1'b0;
         m_rpt[b]   = 1'b0;
         press = 1'b0;
         rel   = 1'b0;
         differ = ((~m_s2[b]) != m_db[b]);
         if (differ) begin
            if (m_cnt[b] == DB - 1) begin
               m_db[b]  = ~m_db[b];
               m_cnt[b] = 0;
               press    = m_db[b];
               rel      = ~m_db[b];
            end else begin
               m_cnt[b]++;
            end
         end else begin
            m_cnt[b] = 0;
         end
         m_pulse[b] = press;
         if (MASK[b]) begin
            if (rel) begin
               m_act[b] = 1'b0;
            end else if (press) begin
               m_act[b] = 1'b1;
               m_run[b] = 0;
            end else if (m_act[b] && !(conflict && (b == BTN_UP || b == BTN_DOWN))) begin
               m_run[b]++;
               if (m_run[b] == RD || (m_run[b] > RD && (m_run[b] - RD) % RP == 0))
                  m_rpt[b] = 1'b1;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
   endtask

   function automatic logic [9:0] dut_out();
      return {held, right, left, down, up, start};
   endfunction

   function automatic logic [9:0] model_out();
      return {m_db, m_pulse | m_rpt};
   endfunction

   task automatic tick(input logic [4:0] k);
      key_n = k;
      @(posedge clk);
      if (rst_n) begin
         model_step();
         edge_n++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      key_n = '1;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      key_n = 5'b00000;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (dut_out() !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got=%b expected=%b", i, dut_out(), 10'd0);
         end
      end
      key_n  = '1;
      rst_n  = 1'b1;
      edge_n = 0;
      for (int i = 0; i < 10; i++) begin
         tick(5'b11111);
         vectors++;
         if (dut_out() !== 10'd0) begin
            errors++;
            $display("FAIL reset_idle edge=%0d got=%b expected=%b", edge_n, dut_out(), 10'd0);
         end
      end
   endtask

   task automatic test_clean_press();
      do_reset();
      for (int i = 0; i < 100; i++) begin
         tick(5'b11110);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL clean_model edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
         vectors++;
         if (start !== (edge_n == DB + 2) || held[0] !== (edge_n >= DB + 2)) begin
            errors++;
            $display("FAIL clean_timing edge=%0d got start=%b held0=%b expected start=%b held0=%b",
                     edge_n, start, held[0], (edge_n == DB + 2), (edge_n >= DB + 2));
         end
      end
      for (int i = 0; i < 12; i++) begin
         tick(5'b11111);
         vectors++;
         if (dut_out() !== model_out() || start !== 1'b0) begin
            errors++;
            $display("FAIL clean_release edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
      end
   endtask

   task automatic test_bounce();
      int pulses, pulse_edge;
      logic [4:0] k;
      pulses = 0;
      pulse_edge = -1;
      do_reset();
      for (int i = 1; i <= 50; i++) begin
         k = 5'b11111;
         if (i <= 3 || i >= 6) k[BTN_LEFT] = 1'b0;
         tick(k);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL bounce_model edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
         if (left) begin
            pulses++;
            pulse_edge = edge_n;
         end
      end
      vectors++;
      if (pulses != 1 || pulse_edge != 6 + DB + 1) begin
         errors++;
         $display("FAIL bounce_pulse got count=%0d edge=%0d expected count=1 edge=%0d",
                  pulses, pulse_edge, 6 + DB + 1);
      end
   endtask

   task automatic test_autorepeat();
      int got_q [$];
      int exp_q [$];
      int clear_edge;
      exp_q = '{6, 26, 34, 42, 50, 58};
      clear_edge = -1;
      do_reset();
      for (int i = 1; i <= 80; i++) begin
         tick(i <= 60 ? 5'b11101 : 5'b11111);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL repeat_model edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
         if (up) got_q.push_back(edge_n);
         if (i > 60 && clear_edge < 0 && !held[BTN_UP]) clear_edge = edge_n;
      end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL repeat_count got=%0d expected=%0d", got_q.size(), exp_q.size());
      end else begin
         for (int j = 0; j < exp_q.size(); j++) begin
            if (got_q[j] != exp_q[j]) begin
               errors++;
               $display("FAIL repeat_edge idx=%0d got=%0d expected=%0d", j, got_q[j], exp_q[j]);
            end
         end
      end
      vectors++;
      if (clear_edge != 66) begin
         errors++;
         $display("FAIL repeat_held_clear got=%0d expected=66", clear_edge);
      end
   endtask

   task automatic test_conflict();
      int up_q [$];
      int dn_q [$];
      int exp_up [$];
      logic [4:0] k;
      exp_up = '{6, 76, 84, 92, 100};
      do_reset();
      for (int i = 1; i <= 120; i++) begin
         k = 5'b11111;
         if (i <= 100) k[BTN_UP] = 1'b0;
         if (i >= 11 && i <= 60) k[BTN_DOWN] = 1'b0;
         tick(k);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL conflict_model edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
         if (up) up_q.push_back(edge_n);
         if (down) dn_q.push_back(edge_n);
      end
      vectors++;
      if (dn_q.size() != 1 || (dn_q.size() == 1 && dn_q[0] != 16)) begin
         errors++;
         $display("FAIL conflict_down got count=%0d expected count=1 at edge 16", dn_q.size());
      end
      vectors++;
      if (up_q.size() != exp_up.size()) begin
         errors++;
         $display("FAIL conflict_up_count got=%0d expected=%0d", up_q.size(), exp_up.size());
      end else begin
         for (int j = 0; j < exp_up.size(); j++) begin
            if (up_q[j] != exp_up[j]) begin
               errors++;
               $display("FAIL conflict_up_edge idx=%0d got=%0d expected=%0d", j, up_q[j], exp_up[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int dn_q [$];
      do_reset();
      for (int i = 1; i <= 30; i++) begin
         tick(5'b11011);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL midreset_pre edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (dut_out() !== 10'd0) begin
         errors++;
         $display("FAIL midreset_drop got=%b expected=%b", dut_out(), 10'd0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (dut_out() !== 10'd0) begin
            errors++;
            $display("FAIL midreset_hold cyc=%0d got=%b expected=%b", i, dut_out(), 10'd0);
         end
      end
      rst_n  = 1'b1;
      edge_n = 0;
      for (int i = 1; i <= 30; i++) begin
         tick(5'b11011);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL midreset_post edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
         if (down) dn_q.push_back(edge_n);
      end
      vectors++;
      if (dn_q.size() != 2 || (dn_q.size() == 2 && (dn_q[0] != 6 || dn_q[1] != 26))) begin
         errors++;
         $display("FAIL midreset_pulses got count=%0d expected pulses at edges 6 and 26", dn_q.size());
      end
   endtask

   task automatic test_simultaneous();
      int pulse_bits;
      pulse_bits = 0;
      do_reset();
      for (int i = 1; i <= 60; i++) begin
         tick(5'b00000);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL simul_model edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
         pulse_bits += int'(start) + int'(up) + int'(down) + int'(left) + int'(right);
         if (edge_n == DB + 2) begin
            vectors++;
            if (dut_out() !== 10'b11111_11111) begin
               errors++;
               $display("FAIL simul_edge got=%b expected=%b", dut_out(), 10'b11111_11111);
            end
         end
      end
      vectors++;
      if (pulse_bits != 5) begin
         errors++;
         $display("FAIL simul_total got=%0d expected=5", pulse_bits);
      end
   endtask

   task automatic test_random();
      int hold_left [5];
      logic [4:0] k;
      k = '1;
      for (int b = 0; b < NUM_BTN; b++) hold_left[b] = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NUM_BTN; b++) begin
            if (hold_left[b] == 0) begin
               k[b] = ~k[b];
               if ($urandom_range(0, 1) == 1)
                  hold_left[b] = int'($urandom_range(1, DB + 1));
               else
                  hold_left[b] = int'($urandom_range(DB + 2, 70));
            end else begin
               hold_left[b]--;
            end
         end
         tick(k);
         vectors++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL random edge=%0d got=%b expected=%b", edge_n, dut_out(), model_out());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_autorepeat();
      test_conflict();
      test_reset_mid();
      test_simultaneous();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout vectors=%0d miscompares=%0d", vectors, errors);
      $fatal(1, "bench time limit expired");
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input front-end for the time-setting path.
- Takes the five raw active-low board pushbuttons (start, up, down, left, right).
- Synchronises and debounces each button, then emits single-cycle press pulses on clk_50MHz for the clock-setting logic.
- Adds hold-to-repeat auto-repeat pulses on up/down, so a held key scrolls hours/minutes/seconds.

Parameters:
- DEBOUNCE_CYC, 500000, consecutive cycles a synchronised level must differ from the debounced state before that state flips (10 ms at 50 MHz).
- REPEAT_DELAY_CYC, 25000000, cycles from the press pulse to the first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD_CYC, 5000000, cycles between subsequent auto-repeat pulses (10 Hz).
- REPEAT_MASK, 5'b00110, per-button auto-repeat enable, bit order per BTN_* constants (up and down only).

Ports:
- clk_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_n  in  5  raw buttons, active-low, asynchronous to clk; bit order [0] start, [1] up, [2] down, [3] left, [4] right.
- start  out  1  one-cycle press pulse.
- up  out  1  one-cycle pulse: press or auto-repeat.
- down  out  1  one-cycle pulse: press or auto-repeat.
- left  out  1  one-cycle press pulse.
- right  out  1  one-cycle press pulse.
- held  out  5  debounced level per button, 1 = pressed, same bit order as key_n.

Behaviour:
- Reset (reset low, asynchronous):
  - synchroniser flops = 1 (released); debounced state = released; all counters = 0; repeat FSMs = IDLE.
  - All outputs = 0.
- Synchroniser: two flops per bit on clk_50MHz. No combinational path from key_n to any output.
- Debounce, per button:
  - Counter increments on every edge where the synchronised level differs from the debounced state.
  - Counter clears on any edge where they agree.
  - On the edge where the counter equals DEBOUNCE_CYC-1 and the levels still differ, the debounced state flips and the counter clears.
  - The same rule applies to press and release.
- Press pulse:
  - Registered; high for exactly one cycle, in the cycle after the debounced state flips to pressed.
  - With key_n going low cleanly before edge 1, the pulse is high between edge DEBOUNCE_CYC+2 and edge DEBOUNCE_CYC+3.
  - Release never produces a pulse.
- held: equals the debounced state, registered with the same timing as the pulse.
- Repeat FSM, per button with REPEAT_MASK set; states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on the press flip; timer loaded with 0.
  - DELAY: timer counts each cycle. When it reaches REPEAT_DELAY_CYC-1, emit one pulse and go to REPEAT with timer 0.
  - REPEAT: pulse every REPEAT_PERIOD_CYC cycles.
  - Any state -> IDLE on the release flip. No pulse is emitted in the release cycle.
  - The output pulse is the OR of the press pulse and the repeat pulse. The two never coincide.
- Conflict: while up and down are both held, both repeat FSMs hold in their current state with timers frozen and emit no repeat pulses. Initial press pulses are unaffected.
  - Once one of the pair is released, the other resumes its timer from the frozen value.
- Independence:
  - Buttons are otherwise independent; simultaneous presses give simultaneous pulses.
  - Buttons with REPEAT_MASK clear emit exactly one pulse per debounced press, regardless of hold length.
- Bounce: any disagreement run shorter than DEBOUNCE_CYC cycles is absorbed. It produces no pulse and no change on held.
- Mid-operation reset: outputs drop immediately. After reset deasserts, a key still held low is treated as a new press; a full debounce interval is required before its pulse.
- Counter widths: $clog2 of each parameter, minimum 1 bit. Timers never wrap, because they are cleared at their terminal counts.
- Parameters are legal only with DEBOUNCE_CYC >= 2 and REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC >= 2.

Decomposition:
- Package button_pkg holds:
  - BTN_START=0, BTN_UP=1, BTN_DOWN=2, BTN_LEFT=3, BTN_RIGHT=4, NUM_BTN=5.
  - The repeat state enum (IDLE, DELAY, REPEAT).
- Sub-module button_debounce, instantiated five times. It contains the synchroniser, debounce counter, held register and press-pulse register.
- Repeat FSMs, the up/down conflict logic and the output OR live in button_conditioner.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=8):
- Clean press: key_n[0] low before edge 1, held 100 cycles -> start high only between edges 6 and 7; held[0]=1 from edge 6; no further start pulses.
- Bounce: key_n[3] low for 3 cycles, high 2, low steady -> exactly one left pulse, 6 edges after the final low begins; no earlier pulse.
- Auto-repeat: key_n[1] held 60 cycles -> up pulses at cycle 0 (press), +20, +28, +36, +44, +52 relative to the press pulse. Release -> held[1] clears 6 edges after key_n rises, with no pulse.
- Conflict: hold up; press down 10 cycles after the up pulse -> down press pulse only, no repeats while both held. Release down -> up's next repeat occurs 10 cycles after its timer resumes.
- Reset mid-hold: during REPEAT, assert reset for 3 cycles with key_n[2] held low -> all outputs 0 immediately; after release, the down pulse arrives 6 edges later, then the first repeat 20 cycles after that.
- Simultaneous: key_n = 5'b00000 on the same edge -> all five pulses in the same cycle; held = 5'b11111; up/down frozen, no repeats.
